// File: rtl/conv_input_loader.sv
// -----------------------------------------------------------------------------
// conv_input_loader
//
// Purpose:
//   Staging buffer in front of the convolution datapath. Stream words arriving
//   over a valid/ready handshake are written into a local frame buffer. Once a
//   full frame of DEPTH words is held, a one-cycle tstart pulse launches the
//   convolution. The convolution then reads the frame through the v0 port
//   (one-cycle registered read) until it releases the frame with conv_done.
//
// Build option:
//   CONV_PINGPONG_EN - when defined, two banks are used. The fill bank and the
//                      compute bank swap at START, so the next frame can be
//                      filled while the convolution works on the previous one.
//                      When undefined, a single bank is used and input is
//                      stalled for the whole time the convolution is busy.
//
// Parameters:
//   DATA_W  width of stream words and read data
//   ADDR_W  width of v0_addr
//   DEPTH   words per frame, 2 .. 2**ADDR_W
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   stream word present
//   in_ready    out  loader accepts a word this cycle
//   in_data     in   stream word
//   v0_addr     in   read address from the convolution
//   v0_rd_en    in   read strobe from the convolution
//   v0_rd_data  out  registered read data (one-cycle latency)
//   tstart      out  one-cycle start pulse to the convolution
//   conv_done   in   convolution has finished with the current frame
//   err         out  sticky protocol error flag
// -----------------------------------------------------------------------------
module conv_input_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] v0_addr,
  input  logic              v0_rd_en,
  output logic [DATA_W-1:0] v0_rd_data,
  output logic              tstart,
  input  logic              conv_done,
  output logic              err
);

  // Index width covering exactly the frame; v0_addr may be wider than needed.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  WLAST   = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rdy_en_q;
  logic [IDX_W-1:0]  wptr_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_data_p1;

  logic              xfer;
  logic              last_xfer;
  logic              frame_busy;
  logic              done_ok;
  logic              done_err;
  logic              addr_oob;
  logic [IDX_W-1:0]  rd_idx;

`ifdef CONV_PINGPONG_EN
  logic              busy_q;
  logic              fbank_q;
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
`else
  logic [DATA_W-1:0] mem0 [DEPTH];
`endif

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (wptr_q == WLAST);
  assign addr_oob  = ({1'b0, v0_addr} >= DEPTH_X);
  assign rd_idx    = v0_addr[IDX_W-1:0];

`ifdef CONV_PINGPONG_EN
  // The FSM returns to FILL right after START, so "a frame is in flight" is
  // tracked separately from the state.
  assign frame_busy = busy_q;
`else
  assign frame_busy = (state_q == S_BUSY);
`endif

  // A conv_done with no frame in flight (including the START cycle itself)
  // is a protocol error and is otherwise ignored.
  assign done_ok  = conv_done && frame_busy;
  assign done_err = conv_done && !frame_busy;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (last_xfer) begin
`ifdef CONV_PINGPONG_EN
          // The previous frame may be released in the very cycle the last
          // word lands; only park in FULL if it is still held afterwards.
          state_d = (busy_q && !conv_done) ? S_FULL : S_START;
`else
          state_d = S_START;
`endif
        end
      end
      S_START: begin
`ifdef CONV_PINGPONG_EN
        state_d = S_FILL;
`else
        state_d = S_BUSY;
`endif
      end
      S_BUSY: begin
        if (done_ok) begin
          state_d = S_FILL;
        end
      end
      S_FULL: begin
        if (done_ok) begin
          state_d = S_START;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // rdy_en_q keeps in_ready low through reset and lets it rise on the first
  // edge after release.
  always_comb begin
    in_ready = rdy_en_q && (state_q == S_FILL);
    tstart   = (state_q == S_START);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
    end else if (last_xfer) begin
      wptr_q <= '0;
    end else if (xfer) begin
      wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (done_err || (v0_rd_en && addr_oob)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

`ifdef CONV_PINGPONG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else if (state_q == S_START) begin
      busy_q <= 1'b1;
    end else if (done_ok) begin
      busy_q <= 1'b0;
    end
  end

  // fbank_q is the bank being filled; the other one is the compute bank.
  // Toggling at START hands the just-filled bank to the convolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbank_q <= 1'b0;
    end else if (state_q == S_START) begin
      fbank_q <= ~fbank_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Frame storage: write port (no reset on contents)
  // ---------------------------------------------------------------------------
`ifdef CONV_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (xfer && !fbank_q) begin
      mem0[wptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && fbank_q) begin
      mem1[wptr_q] <= in_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem0[wptr_q] <= in_data;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read port, stage p1: registered, read-first against a same-cycle write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else if (v0_rd_en) begin
      if (addr_oob) begin
        rd_data_p1 <= '0;
      end else begin
`ifdef CONV_PINGPONG_EN
        rd_data_p1 <= fbank_q ? mem0[rd_idx] : mem1[rd_idx];
`else
        rd_data_p1 <= mem0[rd_idx];
`endif
      end
    end
  end

  assign v0_rd_data = rd_data_p1;

endmodule

// File: tb/tb_conv_input_loader.sv
module tb_conv_input_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] v0_addr = '0;
  logic              v0_rd_en = 1'b0;
  logic [DATA_W-1:0] v0_rd_data;
  logic              tstart;
  logic              conv_done = 1'b0;
  logic              err;

  int n_vec = 0;
  int n_err = 0;

  // Expected content of the bank the convolution currently reads.
  logic [DATA_W-1:0] model [DEPTH];

  conv_input_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .v0_addr(v0_addr), .v0_rd_en(v0_rd_en),
    .v0_rd_data(v0_rd_data), .tstart(tstart), .conv_done(conv_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; v0_rd_en = 1'b0; conv_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_model(input logic [DATA_W-1:0] base);
    for (int i = 0; i < DEPTH; i++) model[i] = base + DATA_W'(i);
  endtask

  // Streams words base+start .. base+DEPTH-1; counts accepted transfers and
  // any tstart seen before the last one. Ends #1 after the last transfer edge.
  task automatic fill_frame(input logic [DATA_W-1:0] base, input bit rnd,
                            input int start, output int got, output int early);
    int budget;
    logic acc;
    got = start; early = 0; budget = 0;
    while (got < DEPTH && budget < 4000) begin
      in_valid = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      in_data  = in_valid ? (base + DATA_W'(got)) : DATA_W'($urandom);
      acc = in_valid && in_ready;
      if (tstart) early++;
      tick();
      if (acc) got++;
      budget++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL rst_tstart: got %b want 0", tstart); end
    n_vec++; if (v0_rd_data !== '0) begin n_err++; $display("FAIL rst_rd_data: got %0h want 0", v0_rd_data); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rel_in_ready_early: got %b want 0", in_ready); end
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready_rise: got %b want 1", in_ready); end
  endtask

  task automatic test_fill_held();
    int got, early;
    int addrs [3];
    addrs[0] = 0; addrs[1] = 1; addrs[2] = 255;
    fill_frame(32'd0, 1'b0, 0, got, early);
    set_model(32'd0);
    n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL held_count: got %0d want %0d", got, DEPTH); end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL held_early_tstart: got %0d want 0", early); end
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL held_tstart: got %b want 1", tstart); end
    tick();
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL held_tstart_once: got %b want 0", tstart); end
`ifndef CONV_PINGPONG_EN
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL held_busy_ready: got %b want 0", in_ready); end
`endif
    v0_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v0_addr = ADDR_W'(addrs[k]);
      tick();
      n_vec++; if (v0_rd_data !== model[addrs[k]]) begin n_err++; $display("FAIL held_read[%0d]: got %0h want %0h", addrs[k], v0_rd_data, model[addrs[k]]); end
    end
    v0_rd_en = 1'b0; v0_addr = 9'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (v0_rd_data !== model[255]) begin n_err++; $display("FAIL held_rd_hold: got %0h want %0h", v0_rd_data, model[255]); end
    end
  endtask

  task automatic test_read_oob();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL oob_err_pre: got %b want 0", err); end
    v0_rd_en = 1'b1; v0_addr = 9'd300;
    tick();
    n_vec++; if (v0_rd_data !== '0) begin n_err++; $display("FAIL oob_rd_zero: got %0h want 0", v0_rd_data); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL oob_err_set: got %b want 1", err); end
    v0_addr = 9'd5;
    tick();
    n_vec++; if (v0_rd_data !== model[5]) begin n_err++; $display("FAIL oob_next_read: got %0h want %0h", v0_rd_data, model[5]); end
    v0_rd_en = 1'b0;
    tick();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL oob_err_sticky: got %b want 1", err); end
`ifndef CONV_PINGPONG_EN
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL oob_state_kept: got %b want 0", in_ready); end
`endif
  endtask

  task automatic test_conv_done_busy();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL done_ready_rise: got %b want 1", in_ready); end
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL done_no_tstart: got %b want 0", tstart); end
  endtask

  task automatic test_random_fill();
    int got, early, a, off;
    logic [DATA_W-1:0] base;
    base = DATA_W'($urandom);
    fill_frame(base, 1'b1, 0, got, early);
    set_model(base);
    n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", got, DEPTH); end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL rnd_early_tstart: got %0d want 0", early); end
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL rnd_tstart: got %b want 1", tstart); end
    tick();
    off = int'($urandom_range(0, 255));
    v0_rd_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      a = (k * 37 + off) % DEPTH;
      v0_addr = ADDR_W'(a);
      tick();
      n_vec++; if (v0_rd_data !== model[a]) begin n_err++; $display("FAIL rnd_read[%0d]: got %0h want %0h", a, v0_rd_data, model[a]); end
    end
    v0_rd_en = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL rnd_err_still_set: got %b want 1", err); end
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  task automatic test_done_errors();
    int got, early;
    // conv_done coinciding with tstart is an error and leaves the frame busy
    do_reset();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL de_err_after_reset: got %b want 0", err); end
    fill_frame(32'h0000_4000, 1'b1, 0, got, early);
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL de_tstart: got %b want 1", tstart); end
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL de_start_done_err: got %b want 1", err); end
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL de_start_done_tstart: got %b want 0", tstart); end
    tick();
`ifndef CONV_PINGPONG_EN
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL de_still_busy: got %b want 0", in_ready); end
`endif
    // conv_done while filling is an error and does not disturb the fill
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'd500 + DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL de_fill_done_err: got %b want 1", err); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL de_fill_state_kept: got %b want 1", in_ready); end
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL de_fill_no_tstart: got %b want 0", tstart); end
    fill_frame(32'd500, 1'b1, 10, got, early);
    set_model(32'd500);
    n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL de_fill_count: got %0d want %0d", got, DEPTH); end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL de_fill_early: got %0d want 0", early); end
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL de_fill_tstart: got %b want 1", tstart); end
    tick();
    v0_rd_en = 1'b1;
    for (int a = 0; a < 12; a++) begin
      v0_addr = ADDR_W'(a);
      tick();
      n_vec++; if (v0_rd_data !== model[a]) begin n_err++; $display("FAIL de_read[%0d]: got %0h want %0h", a, v0_rd_data, model[a]); end
    end
    v0_rd_en = 1'b0;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int got, early;
    logic [DATA_W-1:0] base2;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 32'hA000 + DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
    v0_rd_en = 1'b1; v0_addr = 9'd400;
    tick();
    v0_addr = 9'd50;
    tick();
    v0_rd_en = 1'b0;
`ifndef CONV_PINGPONG_EN
    n_vec++; if (v0_rd_data !== 32'hA032) begin n_err++; $display("FAIL mr_partial_read: got %0h want a032", v0_rd_data); end
`endif
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mr_err_pre: got %b want 1", err); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mr_in_ready: got %b want 0", in_ready); end
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL mr_tstart: got %b want 0", tstart); end
    n_vec++; if (v0_rd_data !== '0) begin n_err++; $display("FAIL mr_rd_data: got %0h want 0", v0_rd_data); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mr_err: got %b want 0", err); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready_back: got %b want 1", in_ready); end
    base2 = DATA_W'($urandom);
    fill_frame(base2, 1'b1, 0, got, early);
    set_model(base2);
    n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL mr_count: got %0d want %0d", got, DEPTH); end
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL mr_early_tstart: got %0d want 0", early); end
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL mr_tstart_after: got %b want 1", tstart); end
    tick();
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL mr_tstart_once: got %b want 0", tstart); end
    v0_rd_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      v0_addr = ADDR_W'(a);
      tick();
      n_vec++; if (v0_rd_data !== model[a]) begin n_err++; $display("FAIL mr_read[%0d]: got %0h want %0h", a, v0_rd_data, model[a]); end
    end
    v0_rd_en = 1'b0;
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
  endtask

`ifdef CONV_PINGPONG_EN
  task automatic test_pingpong();
    int got, early;
    int addrs [3];
    addrs[0] = 0; addrs[1] = 1; addrs[2] = 255;
    do_reset();
    fill_frame(32'd0, 1'b0, 0, got, early);
    set_model(32'd0);
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL pp_tstart_a: got %b want 1", tstart); end
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pp_no_bubble: got %b want 1", in_ready); end
    fill_frame(32'd1000, 1'b0, 0, got, early);
    n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL pp_count_b: got %0d want %0d", got, DEPTH); end
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL pp_full_no_tstart: got %b want 0", tstart); end
    v0_rd_en = 1'b1; v0_addr = 9'd7;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pp_full_ready: got %b want 0", in_ready); end
      tick();
    end
    v0_rd_en = 1'b0;
    n_vec++; if (v0_rd_data !== model[7]) begin n_err++; $display("FAIL pp_read_a: got %0h want %0h", v0_rd_data, model[7]); end
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    set_model(32'd1000);
    n_vec++; if (tstart !== 1'b1) begin n_err++; $display("FAIL pp_tstart_b: got %b want 1", tstart); end
    tick();
    n_vec++; if (tstart !== 1'b0) begin n_err++; $display("FAIL pp_tstart_b_once: got %b want 0", tstart); end
    v0_rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v0_addr = ADDR_W'(addrs[k]);
      tick();
      n_vec++; if (v0_rd_data !== model[addrs[k]]) begin n_err++; $display("FAIL pp_read_b[%0d]: got %0h want %0h", addrs[k], v0_rd_data, model[addrs[k]]); end
    end
    v0_rd_en = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL pp_err: got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_held();
    test_read_oob();
    test_conv_done_busy();
    test_random_fill();
    test_done_errors();
    test_reset_midframe();
`ifdef CONV_PINGPONG_EN
    test_pingpong();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_input_loader.md
# conv_input_loader

Input staging stage directly upstream of the `convolution` datapath. It accepts a stream of 32-bit words over a valid/ready handshake and writes them into a local frame buffer. When a complete frame of `DEPTH` words is held, it pulses `tstart` to launch the convolution. It then serves the convolution's `v0` read port with one-cycle read latency until the frame is released by `conv_done`.

## Interface
Parameters:
- `DATA_W`, 32, width of stream words and `v0_rd_data`
- `ADDR_W`, 8, width of `v0_addr`
- `DEPTH`, 256, words per frame; legal range 2..2^ADDR_W

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  stream word present
- `in_ready`  out  1  loader accepts a word this cycle
- `in_data`  in  DATA_W  stream word
- `v0_addr`  in  ADDR_W  read address from convolution
- `v0_rd_en`  in  1  read strobe from convolution
- `v0_rd_data`  out  DATA_W  registered read data
- `tstart`  out  1  one-cycle start pulse to convolution
- `conv_done`  in  1  one-cycle pulse: convolution has finished with the current frame
- `err`  out  1  sticky protocol error flag

## Operation
- Handshake: a word transfers on a rising edge with `in_valid && in_ready`. `in_data` is written at the write counter `wptr`, and `wptr` increments. `in_valid` may be asserted without `in_ready`; no word is lost or duplicated.
- FSM states: FILL, START, BUSY (plus FULL when `CONV_PINGPONG_EN` is defined).
- FILL:
  - `in_ready`=1.
  - The transfer at `wptr==DEPTH-1` sets `wptr` to 0 and moves the FSM to START.
- START:
  - `in_ready`=0 and `tstart`=1 for exactly one cycle, then BUSY.
- BUSY:
  - `in_ready`=0.
  - `conv_done` moves the FSM to FILL.
- Reads:
  - `v0_rd_en` high: `v0_rd_data` gets the content of `v0_addr` of the compute bank on the next edge.
  - `v0_addr >= DEPTH`: returns 0.
  - `v0_rd_en` low: `v0_rd_data` holds its value.
- Read-during-write to the same bank and address returns the old content (read-first).
- `err` is set, and stays set until reset, when:
  - `conv_done` arrives while no frame has been started (not BUSY), or
  - `v0_rd_en` is asserted with `v0_addr >= DEPTH`.
  - In both cases the event itself is otherwise ignored.
- Storage is inferred RAM: DEPTH x DATA_W per bank, no reset on contents.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0. `tstart`=0, `v0_rd_data`=0, `err`=0, `wptr`=0, state FILL, bank select 0. `in_ready` rises on the first edge after reset release.
- `tstart` asserts on the edge after the last word's transfer, giving a 1-cycle fill-to-start latency. It is never high for 2 consecutive cycles.
- Read latency: exactly 1 cycle from `v0_rd_en`/`v0_addr` sample to `v0_rd_data`. Back-to-back reads are supported every cycle.
- `conv_done` in BUSY: `in_ready` rises on the following cycle.
- If `conv_done` and `tstart` fall in the same cycle, `conv_done` is an error (the frame is not yet BUSY).
- Reset mid-frame: partial frame is discarded, `wptr`=0, no `tstart` is emitted.

## Configuration
- `CONV_PINGPONG_EN` defined: two banks; the fill bank and the compute bank swap at START.
  - After START the FSM returns to FILL on the other bank immediately, with no bubble beyond the START cycle, while the convolution reads the compute bank.
  - Filling the last word while a frame is still busy enters FULL: `in_ready`=0 until `conv_done`, then START (swap + `tstart`) on the next cycle.
- `CONV_PINGPONG_EN` undefined: a single bank, and input is stalled for the whole BUSY period as described in Operation.

## Test plan
- Reset release, DEPTH=256, stream values 0..255 with `in_valid` held high → `tstart` pulses once, 1 cycle after word 255; `in_ready`=0 afterwards (single-bank build).
- After `tstart`, read addresses 0, 1, 255 on consecutive cycles → `v0_rd_data` = 0, 1, 255 one cycle after each; it holds 255 when `v0_rd_en` drops.
- Randomly toggle `in_valid` while filling → exactly 256 words captured; `tstart` follows the 256th transfer; memory readback matches.
- `CONV_PINGPONG_EN` build, two frames 0..255 and 1000..1255 with no `conv_done` → second fill stalls in FULL with `in_ready`=0. A `conv_done` pulse yields `tstart` 1 cycle later, and reads return 1000+addr.
- `conv_done` pulsed in FILL, or a read at addr 300 with DEPTH=256 → `err`=1 and stays set; state is unchanged and the read returns 0.
- Assert `rst_n`=0 after 100 words → outputs return to reset values. Refilling 256 words after release produces a single `tstart`, and data starts at address 0.
